prog_clock_divider: RTL
=======================

// Module: prog_clock_divider
// PURPOSE
//   Multi-channel programmable clock divider; successor of the fixed 0.5 Hz divider.
//   Each channel produces a square-wave enable clock and a one-cycle tick from clk.
//   Per-channel divide ratios are runtime-loadable and take effect only at half-period boundaries, so output is glitch-free.
//   Feeds slow-step/debug clocks and LED/display timers in the CPU top level.
// PARAMETERS
//   NUM_CH      2           number of independent divider channels (>=1)
//   CNT_W       28          counter/divide-value width in bits
//   DEFAULT_DIV 50_000_000  terminal count loaded into every channel at reset (must fit CNT_W)
// PORTS
//   clk       in   1             system clock (50 MHz on board)
//   rst       in   1             synchronous, active-high reset
//   en        in   NUM_CH        per-channel count enable
//   load      in   NUM_CH        per-channel pulse: capture div_val[ch] as pending terminal count
//   div_val   in   NUM_CH*CNT_W  packed terminal counts; channel ch in bits [ch*CNT_W +: CNT_W]
//   clk_out   out  NUM_CH        divided square wave, registered
//   tick      out  NUM_CH        1-cycle pulse coincident with each clk_out toggle
//   sync_start in  1             only with CLKDIV_SYNC_START_EN (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (rst=1 at posedge): counter=0, clk_out=0, tick=0, active_div=DEFAULT_DIV, pending_valid=0. Reset wins over all.
//   - Per channel, en=1: if counter==active_div -> counter<=0, clk_out<=~clk_out, tick<=1; else counter<=counter+1, tick<=0.
//   - Half period = active_div+1 cycles; full period = 2*(active_div+1). active_div=0 -> clk_out toggles every cycle (clk/2), tick stuck 1.
//   - en=0: counter, clk_out, active_div hold; tick<=0. Re-enable resumes count from held value.
//   - load=1: pending<=div_val[ch], pending_valid<=1. Later load before boundary overwrites pending.
//   - Boundary (terminal count with en=1): if pending_valid, active_div<=pending, pending_valid<=0; new value governs next half period.
//   - load on same cycle as boundary: div_val used directly as new active_div; pending_valid stays 0.
//   - load while en=0: applied immediately (active_div<=div_val, counter<=0, clk_out holds); avoids stale ratio on restart.
//   - Lowering active_div below current counter never happens mid-half-period (boundary-only update), so no wrap past 2^CNT_W.
//   - Counter arithmetic CNT_W bits unsigned; comparison is equality only.
//   - Latency: clk_out/tick change one clk after the terminal-count cycle; load->effect at next boundary.
//   - Channels fully independent; no cross-channel phase relationship unless sync_start used.
// CONFIGURATION
//   CLKDIV_SYNC_START_EN defined: port sync_start exists; sync_start=1 (rst=0) clears counter, clk_out, tick on all channels next edge,
//     applies any pending value as active_div; priority below rst, above en/load-boundary logic; gives phase-aligned channels.
//   Undefined: no sync_start port; channel phase determined only by reset and en history.
// STRUCTURE
//   Package clkdiv_pkg: localparam CLKDIV_CNT_W=28, CLKDIV_DEFAULT_DIV=50_000_000, typedef logic [CLKDIV_CNT_W-1:0] clkdiv_cnt_t.
//   Sub-module clkdiv_channel: one counter + active/pending registers + clk_out/tick; top instantiates NUM_CH via generate.
//   Top only unpacks div_val and fans out clk/rst/sync_start.
// TESTING
//   1. NUM_CH=2, rst 3 cycles, en=11, DEFAULT_DIV=3 -> both clk_out period 8 cycles, tick every 4, first toggle 4 cycles after en.
//   2. ch0 running div=3, load div_val=1 mid-half-period -> current half stays 4 cycles, subsequent halves 2 cycles; ch1 unaffected.
//   3. load asserted exactly on terminal-count cycle with div_val=0 -> next half period 1 cycle, clk_out toggles every clk.
//   4. en0 dropped at counter=2 for 10 cycles -> clk_out0 and counter frozen, tick0=0; resumes and toggles 2 cycles after re-enable.
//   5. rst pulsed mid-count with pending load -> clk_out=0, counter=0, active_div=DEFAULT_DIV, pending discarded.
//   6. CLKDIV_SYNC_START_EN, ch0 div=2, ch1 div=5 out of phase, sync_start 1 cycle -> both clk_out=0, counters 0, toggles at 3 and 6 cycles.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared constants and types for the programmable clock divider.
package clkdiv_pkg;

  localparam int          CLKDIV_CNT_W       = 28;
  localparam int unsigned CLKDIV_DEFAULT_DIV = 50_000_000;

  typedef logic [CLKDIV_CNT_W-1:0] clkdiv_cnt_t;

endpackage : clkdiv_pkg

// File: rtl/clkdiv_channel.sv
// One divider channel: up-counter, active/pending terminal counts,
// registered square wave and toggle tick.
// Optional macro CLKDIV_SYNC_START_EN adds the sync_start input.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int          CNT_W       = CLKDIV_CNT_W,
  parameter int unsigned DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst,
`ifdef CLKDIV_SYNC_START_EN
  input  logic             sync_start,
`endif
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] div_val,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] active_div;
  logic [CNT_W-1:0] pending;
  logic             pending_valid;
  logic             terminal;

  // Terminal count reached in the current half period.
  always_comb begin
    terminal = (counter == active_div);
  end

  // Counter, ratio registers and outputs; ratio changes only at half-period
  // boundaries while running, immediately while stopped.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter       <= '0;
      clk_out       <= 1'b0;
      tick          <= 1'b0;
      active_div    <= CNT_W'(DEFAULT_DIV);
      pending       <= '0;
      pending_valid <= 1'b0;
    end
`ifdef CLKDIV_SYNC_START_EN
    else if (sync_start) begin
      // Realign phase: restart from zero with the newest requested ratio.
      counter       <= '0;
      clk_out       <= 1'b0;
      tick          <= 1'b0;
      pending_valid <= 1'b0;
      if (load) begin
        active_div <= div_val;
      end else if (pending_valid) begin
        active_div <= pending;
      end
    end
`endif
    else if (en) begin
      if (terminal) begin
        counter <= '0;
        clk_out <= ~clk_out;
        tick    <= 1'b1;
        // A load coinciding with the boundary bypasses the pending register.
        if (load) begin
          active_div    <= div_val;
          pending_valid <= 1'b0;
        end else if (pending_valid) begin
          active_div    <= pending;
          pending_valid <= 1'b0;
        end
      end else begin
        counter <= counter + CNT_W'(1);
        tick    <= 1'b0;
        if (load) begin
          pending       <= div_val;
          pending_valid <= 1'b1;
        end
      end
    end else begin
      tick <= 1'b0;
      // Stopped channel: take the new ratio now so a restart is not stale.
      if (load) begin
        active_div    <= div_val;
        counter       <= '0;
        pending_valid <= 1'b0;
      end
    end
  end

endmodule : clkdiv_channel

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider top: unpacks per-channel divide
// values and fans out clk/rst (and sync_start) to NUM_CH channels.
// Optional macro CLKDIV_SYNC_START_EN adds the sync_start port.
module prog_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int          NUM_CH      = 2,
  parameter int          CNT_W       = CLKDIV_CNT_W,
  parameter int unsigned DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef CLKDIV_SYNC_START_EN
  input  logic                    sync_start,
`endif
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*CNT_W-1:0] div_val,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick
);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    clkdiv_channel #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_channel (
      .clk       (clk),
      .rst       (rst),
`ifdef CLKDIV_SYNC_START_EN
      .sync_start(sync_start),
`endif
      .en        (en[ch]),
      .load      (load[ch]),
      .div_val   (div_val[ch*CNT_W +: CNT_W]),
      .clk_out   (clk_out[ch]),
      .tick      (tick[ch])
    );
  end

endmodule : prog_clock_divider
